// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding the F->D pipeline register.
// Holds the fetch PC and keeps at most one request outstanding to instruction
// memory. A single skid slot holds a returned instruction while decode is
// stalled. A redirect flushes everything in flight; a response that was
// already requested when the redirect arrived is dropped when it returns.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   stallF           1 = F->D register holds; 0 = it captures pcF/instF
//   redirect_valid   taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc      redirect target
//   imem_req/addr    request to instruction memory (combinational)
//   imem_ready       memory accepts the request this cycle
//   imem_rvalid      response valid (at least one cycle after acceptance)
//   imem_rdata       response instruction
//   pcF/instF/validF registered fetch outputs
module fetch_unit #(
  parameter logic [11:0] RESET_PC = 12'h000,
  parameter logic [11:0] PC_STEP  = 12'h001,
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallF,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_pc,
  output logic        imem_req,
  output logic [11:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  output logic [11:0] pcF,
  output logic [15:0] instF,
  output logic        validF
);

  localparam int unsigned PC_W   = 12;
  localparam int unsigned INST_W = 16;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                drop_q, drop_d;
  logic [PC_W-1:0]     pcf_q, pcf_d;
  logic [INST_W-1:0]   instf_q, instf_d;
  logic                validf_q, validf_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic                slot_free;

  // Request is held off while reset is asserted so the first request
  // appears in the cycle after reset deasserts.
  always_comb begin
    imem_req  = (state_q == S_REQ) && !reset;
    imem_addr = pc_q;
  end

  assign pcF    = pcf_q;
  assign instF  = instf_q;
  assign validF = validf_q;

  // Next-state and output-slot logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    pcf_d       = pcf_q;
    instf_d     = instf_q;
    validf_d    = validf_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;
    slot_free   = !validf_q || !stallF;

    // Output slot is consumed at every unstalled edge; pcF keeps its value.
    if (!stallF) begin
      validf_d = 1'b0;
      instf_d  = NOP_INST;
    end

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      validf_d = 1'b0;
      instf_d  = NOP_INST;
      drop_d   = 1'b0;
      state_d  = S_REQ;
      case (state_q)
        // A request accepted this cycle still owes a response; drop it later.
        S_REQ: begin
          if (imem_ready) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (!imem_rvalid) begin
            state_d = S_WAIT;
            drop_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_ready) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (slot_free) begin
              pcf_d    = pc_q;
              instf_d  = imem_rdata;
              validf_d = 1'b1;
              pc_d     = pc_q + PC_STEP;
            end else begin
              skid_pc_d   = pc_q;
              skid_inst_d = imem_rdata;
              pc_d        = pc_q + PC_STEP;
              state_d     = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stallF) begin
            pcf_d    = skid_pc_q;
            instf_d  = skid_inst_q;
            validf_d = 1'b1;
            state_d  = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      drop_q      <= 1'b0;
      pcf_q       <= PC_W'(0);
      instf_q     <= NOP_INST;
      validf_q    <= 1'b0;
      skid_pc_q   <= PC_W'(0);
      skid_inst_q <= INST_W'(0);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_q      <= drop_d;
      pcf_q       <= pcf_d;
      instf_q     <= instf_d;
      validf_q    <= validf_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

endmodule
